// File: rtl/dsm_aximm_axis.sv
// Read-side DSM mover: single-beat 64-bit AXI-MM reads are assembled into
// 512-bit words and streamed out through a credit-protected output FIFO.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// RUN    | issuing AR requests, collecting R beats
// DRAIN  | all ARs issued, waiting for the tlast word to leave
// DONE   | command finished, done pulses on the following cycle
module dsm_aximm_axis #(
  parameter int DEPTH     = 128,
  parameter int MAX_OUTST = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [48:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [48:0]          m_axi_dsm_araddr,
  output logic                 m_axi_dsm_arvalid,
  input  logic                 m_axi_dsm_arready,
  output logic [2:0]           m_axi_dsm_arprot,
  input  logic [63:0]          m_axi_dsm_rdata,
  input  logic                 m_axi_dsm_rvalid,
  output logic                 m_axi_dsm_rready,
  input  logic [1:0]           m_axi_dsm_rresp,
  output logic [511:0]         m_axis_dsm_tdata,
  output logic                 m_axis_dsm_tvalid,
  input  logic                 m_axis_dsm_tready,
  output logic [63:0]          m_axis_dsm_tkeep,
  output logic                 m_axis_dsm_tlast,
  output logic                 m_axis_dsm_tuser
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int CW = $clog2(DEPTH * 8) + 2;
  localparam int BW = LEN_WIDTH + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [48:0]          addr_q;
  logic [BW-1:0]        ar_left_q;
  logic [LEN_WIDTH-1:0] words_left_q;
  logic [OW-1:0]        outst_q;
  logic [511:0]         asm_q;
  logic [2:0]           asm_cnt_q;
  logic                 asm_user_q;
  logic                 push_q, push_last_q, push_user_q;
  logic                 err_q, done_q, rready_q;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [513:0]         mem [DEPTH];
  logic [511:0]         tdata_q;
  logic                 tvalid_q, tlast_q, tuser_q;

  logic          cmd_accept, ar_valid, ar_hs, r_hs, r_bad, pop, axis_hs, credit_ok;
  logic [AW:0]   fifo_cnt;
  logic [CW-1:0] words_held, used;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[2:0];

  // Credit counts every beat already promised a slot: in flight, assembling,
  // waiting to be pushed, in the FIFO or in the output register.
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign words_held = CW'(fifo_cnt) + CW'(tvalid_q) + CW'(push_q);
  assign used       = (words_held << 3) + CW'(asm_cnt_q) + CW'(outst_q);
  assign credit_ok  = used < CW'(DEPTH * 8);

  assign cmd_accept = (state_q == S_IDLE) && cmd_valid;
  assign ar_valid   = (state_q == S_RUN) && (ar_left_q != '0) &&
                      (outst_q < OW'(MAX_OUTST)) && credit_ok;
  assign ar_hs      = ar_valid && m_axi_dsm_arready;
  assign r_hs       = m_axi_dsm_rvalid && rready_q && (outst_q != '0);
  assign r_bad      = m_axi_dsm_rresp != 2'b00;
  assign pop        = (wr_ptr_q != rd_ptr_q) && (!tvalid_q || m_axis_dsm_tready);
  assign axis_hs    = tvalid_q && m_axis_dsm_tready;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN:   if (ar_hs && ar_left_q == BW'(1)) state_d = S_DRAIN;
      S_DRAIN: if (axis_hs && tlast_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      ar_left_q    <= '0;
      words_left_q <= '0;
      outst_q      <= '0;
      asm_cnt_q    <= '0;
      asm_user_q   <= 1'b0;
      push_q       <= 1'b0;
      push_last_q  <= 1'b0;
      push_user_q  <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      rready_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      done_q   <= (state_q == S_DONE);
      push_q   <= 1'b0;

      if (cmd_accept) begin
        addr_q       <= {cmd_addr[48:3], 3'b000};
        ar_left_q    <= {cmd_len, 3'b000};
        words_left_q <= cmd_len;
      end else if (ar_hs) begin
        addr_q    <= addr_q + 49'd8;
        ar_left_q <= ar_left_q - BW'(1);
      end

      case ({ar_hs, r_hs})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase

      if (cmd_accept)       err_q <= 1'b0;
      else if (r_hs && r_bad) err_q <= 1'b1;

      if (r_hs) begin
        asm_q[{asm_cnt_q, 6'b0} +: 64] <= m_axi_dsm_rdata;
        asm_cnt_q <= asm_cnt_q + 3'd1;
        if (asm_cnt_q == 3'd7) begin
          push_q       <= 1'b1;
          push_user_q  <= asm_user_q | r_bad;
          push_last_q  <= (words_left_q == LEN_WIDTH'(1));
          words_left_q <= words_left_q - LEN_WIDTH'(1);
          asm_user_q   <= 1'b0;
        end else begin
          asm_user_q <= asm_user_q | r_bad;
        end
      end

      if (push_q) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);

      if (pop) begin
        tvalid_q <= 1'b1;
        tlast_q  <= mem[rd_ptr_q[AW-1:0]][513];
        tuser_q  <= mem[rd_ptr_q[AW-1:0]][512];
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end else if (axis_hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers are flushed, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr_q[AW-1:0]] <= {push_last_q, push_user_q, asm_q};
    if (pop)    tdata_q <= mem[rd_ptr_q[AW-1:0]][511:0];
  end

  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
  assign err               = err_q;
  assign m_axi_dsm_araddr  = addr_q;
  assign m_axi_dsm_arvalid = ar_valid;
  assign m_axi_dsm_arprot  = 3'b000;
  assign m_axi_dsm_rready  = rready_q;
  assign m_axis_dsm_tdata  = tdata_q;
  assign m_axis_dsm_tvalid = tvalid_q;
  assign m_axis_dsm_tkeep  = {64{tvalid_q}};
  assign m_axis_dsm_tlast  = tlast_q;
  assign m_axis_dsm_tuser  = tuser_q;

endmodule

// File: tb/tb_dsm_aximm_axis.sv
// Directed bench for dsm_aximm_axis: a memory model answers every AR with
// data equal to its address one cycle later; the stream side is logged.
module tb_dsm_aximm_axis;

  localparam int DEPTH = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [48:0]  cmd_addr = '0;
  logic [15:0]  cmd_len = '0;
  logic         busy, done, err;
  logic [48:0]  araddr;
  logic         arvalid;
  logic         arready = 1'b1;
  logic [2:0]   arprot;
  logic [63:0]  rdata = '0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [1:0]   rresp = 2'b00;
  logic [511:0] tdata;
  logic         tvalid;
  logic         tready = 1'b1;
  logic [63:0]  tkeep;
  logic         tlast, tuser;

  int errors = 0;
  int checks = 0;

  logic [48:0]  rq[$];
  logic [48:0]  arlog[$];
  logic [511:0] wq[$];
  logic         lq[$];
  logic         uq[$];
  int           rbeat = 0;
  int           err_beat = -1;

  dsm_aximm_axis #(.DEPTH(DEPTH), .MAX_OUTST(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .m_axi_dsm_araddr(araddr), .m_axi_dsm_arvalid(arvalid), .m_axi_dsm_arready(arready),
    .m_axi_dsm_arprot(arprot), .m_axi_dsm_rdata(rdata), .m_axi_dsm_rvalid(rvalid),
    .m_axi_dsm_rready(rready), .m_axi_dsm_rresp(rresp),
    .m_axis_dsm_tdata(tdata), .m_axis_dsm_tvalid(tvalid), .m_axis_dsm_tready(tready),
    .m_axis_dsm_tkeep(tkeep), .m_axis_dsm_tlast(tlast), .m_axis_dsm_tuser(tuser)
  );

  always #5 clk = ~clk;

  // Memory model: in-order, data = address, optional SLVERR on one beat.
  always @(posedge clk) begin
    bit          arf, rf;
    logic [48:0] a;
    arf = arvalid && arready;
    rf  = rvalid && rready;
    a   = araddr;
    #1;
    if (rst) begin
      rq.delete();
      rvalid = 1'b0;
    end else begin
      if (rf) begin
        void'(rq.pop_front());
        rbeat++;
      end
      if (arf) begin
        rq.push_back(a);
        arlog.push_back(a);
      end
      if (rq.size() > 0) begin
        rvalid = 1'b1;
        rdata  = {15'b0, rq[0]};
        rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && tvalid && tready) begin
      wq.push_back(tdata);
      lq.push_back(tlast);
      uq.push_back(tuser);
    end
  end

  function automatic logic [511:0] exp_word(input logic [48:0] base);
    logic [511:0] w;
    for (int j = 0; j < 8; j++) w[64*j +: 64] = {15'b0, base + 49'(8*j)};
    return w;
  endfunction

  task automatic clear_logs();
    arlog.delete();
    wq.delete();
    lq.delete();
    uq.delete();
    rbeat = 0;
    err_beat = -1;
  endtask

  task automatic do_cmd(input logic [48:0] a, input logic [15:0] n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready_low got %b want 0", rready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL reset_rready_high got %b want 1", rready); end
    checks++; if ({cmd_ready, busy, done, err} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl got %b want 1000", {cmd_ready, busy, done, err}); end
    checks++; if ({arvalid, tvalid, tlast, tuser} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b want 0000", {arvalid, tvalid, tlast, tuser}); end
    checks++; if (arprot !== 3'b000) begin errors++; $display("FAIL reset_arprot got %b want 000", arprot); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    do_cmd(49'h1000, 16'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout want pulse"); end
    checks++; if (arlog.size() != 8) begin errors++; $display("FAIL single_ar_count got %0d want 8", arlog.size()); end
    else for (int j = 0; j < 8; j++) begin
      checks++; if (arlog[j] !== 49'h1000 + 49'(8*j)) begin errors++; $display("FAIL single_araddr%0d got %h want %h", j, arlog[j], 49'h1000 + 49'(8*j)); end
    end
    checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_words got %0d want 1", wq.size()); end
    else begin
      checks++; if (wq[0] !== exp_word(49'h1000)) begin errors++; $display("FAIL single_data got %h want %h", wq[0], exp_word(49'h1000)); end
      checks++; if ({lq[0], uq[0]} !== 2'b10) begin errors++; $display("FAIL single_last_user got %b want 10", {lq[0], uq[0]}); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b want 0", done); end
  endtask

  task automatic test_len4();
    bit ok;
    int bad;
    clear_logs();
    arready = 1'b0;
    do_cmd(49'h1000, 16'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++; if ({arvalid, araddr} !== {1'b1, 49'h1000}) begin errors++; $display("FAIL len4_ar_hold got %b/%h want 1/1000", arvalid, araddr); end
    end
    arready = 1'b1;
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len4_done got timeout want pulse"); end
    bad = 0;
    for (int j = 0; j < arlog.size(); j++) if (arlog[j] !== 49'h1000 + 49'(8*j)) bad++;
    checks++; if (arlog.size() != 32 || bad != 0) begin errors++; $display("FAIL len4_ars got %0d ars %0d bad want 32 ars 0 bad", arlog.size(), bad); end
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL len4_words got %0d want 4", wq.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (wq[k] !== exp_word(49'h1000 + 49'(64*k))) begin errors++; $display("FAIL len4_word%0d got %h", k, wq[k]); end
      checks++; if (lq[k] !== (k == 3)) begin errors++; $display("FAIL len4_tlast%0d got %b want %b", k, lq[k], k == 3); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    clear_logs();
    tready = 1'b0;
    do_cmd(49'h10000, 16'(DEPTH + 2));
    repeat (DEPTH * 8 + 300) @(posedge clk);
    #1;
    checks++; if (arlog.size() != DEPTH * 8) begin errors++; $display("FAIL bp_ar_stop got %0d want %0d", arlog.size(), DEPTH * 8); end
    checks++; if ({busy, tvalid, tkeep} !== {2'b11, 64'hFFFF_FFFF_FFFF_FFFF}) begin errors++; $display("FAIL bp_hold got busy=%b tvalid=%b tkeep=%h want 1 1 all-ones", busy, tvalid, tkeep); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL bp_no_words got %0d want 0", wq.size()); end
    @(negedge clk);
    tready = 1'b1;
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout want pulse"); end
    checks++; if (wq.size() != DEPTH + 2) begin errors++; $display("FAIL bp_words got %0d want %0d", wq.size(), DEPTH + 2); end
    else begin
      bad = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin
        if (wq[k] !== exp_word(49'h10000 + 49'(64*k))) bad++;
        if (lq[k] !== (k == DEPTH + 1)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d bad words want 0", bad); end
    end
  endtask

  task automatic test_rresp();
    bit ok;
    clear_logs();
    err_beat = 19;
    do_cmd(49'h2000, 16'd3);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rresp_done got timeout want pulse"); end
    checks++; if (uq.size() != 3) begin errors++; $display("FAIL rresp_words got %0d want 3", uq.size()); end
    else begin
      checks++; if ({uq[0], uq[1], uq[2]} !== 3'b001) begin errors++; $display("FAIL rresp_tuser got %b want 001", {uq[0], uq[1], uq[2]}); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rresp_err got %b want 1", err); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rresp_err_sticky got %b want 1", err); end
    clear_logs();
    do_cmd(49'h3000, 16'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rresp_err_clear got %b want 0", err); end
    wait_done(200, ok);
    checks++; if (!ok || uq.size() != 1 || uq[0] !== 1'b0) begin errors++; $display("FAIL rresp_clean got ok=%b words=%0d want 1 1", ok, uq.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    do_cmd(49'h1_FFFF_FFFF_FFF8, 16'd1);
    wait_done(200, ok);
    checks++; if (!ok || arlog.size() != 8) begin errors++; $display("FAIL wrap_ars got ok=%b n=%0d want 1 8", ok, arlog.size()); end
    else begin
      checks++; if (arlog[0] !== 49'h1_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wrap_ar0 got %h want 1fffffffffff8", arlog[0]); end
      checks++; if (arlog[1] !== 49'h0) begin errors++; $display("FAIL wrap_ar1 got %h want 0", arlog[1]); end
      checks++; if (arlog[7] !== 49'h30) begin errors++; $display("FAIL wrap_ar7 got %h want 30", arlog[7]); end
    end
    clear_logs();
    do_cmd(49'h1005, 16'd1);
    wait_done(200, ok);
    checks++; if (!ok || arlog.size() == 0 || arlog[0] !== 49'h1000) begin errors++; $display("FAIL align_ar0 got ok=%b n=%0d want ar0=1000", ok, arlog.size()); end
    checks++; if (wq.size() != 1 || wq[0] !== exp_word(49'h1000)) begin errors++; $display("FAIL align_data got %0d words want 1 word from 1000", wq.size()); end
  endtask

  task automatic test_len0();
    clear_logs();
    do_cmd(49'h5000, 16'd0);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL len0_first got busy,done=%b want 10", {busy, done}); end
    @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL len0_done got busy,done=%b want 01", {busy, done}); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (arlog.size() != 0 || wq.size() != 0) begin errors++; $display("FAIL len0_quiet got ars=%0d words=%0d want 0 0", arlog.size(), wq.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    clear_logs();
    do_cmd(49'h6000, 16'd2);
    wait_done(300, ok);
    do_cmd(49'h7000, 16'd2);
    wait_done(300, ok);
    checks++; if (!ok || wq.size() != 4) begin errors++; $display("FAIL b2b_words got ok=%b n=%0d want 1 4", ok, wq.size()); end
    else begin
      bad = 0;
      if (wq[0] !== exp_word(49'h6000) || wq[1] !== exp_word(49'h6040)) bad++;
      if (wq[2] !== exp_word(49'h7000) || wq[3] !== exp_word(49'h7040)) bad++;
      if ({lq[0], lq[1], lq[2], lq[3]} !== 4'b0101) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_content got %0d bad groups want 0", bad); end
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_logs();
    do_cmd(49'h4000, 16'd4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({arvalid, tvalid, busy, rready, done, err} !== 6'b000000) begin errors++; $display("FAIL rst_mid_outputs got %b want 000000", {arvalid, tvalid, busy, rready, done, err}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready got %b want 1", cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_logs();
    do_cmd(49'h8000, 16'd1);
    wait_done(200, ok);
    checks++; if (!ok || wq.size() != 1 || wq[0] !== exp_word(49'h8000)) begin errors++; $display("FAIL rst_mid_recover got ok=%b words=%0d want 1 1", ok, wq.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len4();
    test_backpressure();
    test_rresp();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
